// File: rtl/dmem_responder.sv
// Data-memory responder for the pipeline's memory stage: one word access per
// valid/ready handshake, with LATENCY wait states before a one-cycle response.
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall_mem
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_next;

    logic [3:0]        cnt;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic              write_q;
    logic              err_q;
    logic [31:0]       rdata_q;

    logic [31:0] mem [2**ADDR_W];

    logic              accept;
    logic              commit;
    logic              commit_write;
    logic              commit_err;
    logic [ADDR_W-1:0] commit_idx;
    logic [31:0]       commit_wdata;

    // Address bits above the word index only alias; they are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    assign accept = (state == IDLE) && req_valid;

    // With zero wait states the access commits on the acceptance edge itself,
    // so the request inputs must feed the commit path directly.
    always_comb begin
        commit       = 1'b0;
        commit_write = write_q;
        commit_err   = err_q;
        commit_idx   = idx_q;
        commit_wdata = wdata_q;
        if (LATENCY == 0) begin
            commit       = accept;
            commit_write = req_write;
            commit_err   = (req_addr[1:0] != 2'b00);
            commit_idx   = req_addr[ADDR_W+1:2];
            commit_wdata = req_wdata;
        end else begin
            commit = (state == WAIT) && (cnt == 4'd1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                idx_q   <= req_addr[ADDR_W+1:2];
                wdata_q <= req_wdata;
                write_q <= req_write;
                err_q   <= (req_addr[1:0] != 2'b00);
                cnt     <= 4'(LATENCY);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                rdata_q <= (commit_write || commit_err) ? 32'd0 : mem[commit_idx];
            end
        end
    end

    // Contents are intentionally not reset; commit is gated by the reset state.
    always_ff @(posedge clk) begin
        if (commit && commit_write && !commit_err) begin
            mem[commit_idx] <= commit_wdata;
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = resp_valid ? rdata_q : 32'd0;
    assign resp_err   = resp_valid && err_q;
    assign stall_mem  = accept || (state == WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance a uses LATENCY=2, instance b
// uses LATENCY=0; both use ADDR_W=10.
module tb_dmem_responder;

    logic        clk;
    logic        reset_a, reset_b;
    logic        valid_a, write_a, valid_b, write_b;
    logic [31:0] addr_a, wdata_a, addr_b, wdata_b;
    logic        ready_a, rvalid_a, err_a, stall_a;
    logic        ready_b, rvalid_b, err_b, stall_b;
    logic [31:0] rdata_a, rdata_b;

    int checks = 0;
    int passes = 0;

    logic [31:0] rd;
    logic        er;
    int          stall_count;
    int          resp_count;
    logic [2:0]  exp_flags;

    dmem_responder #(.ADDR_W(10), .LATENCY(2)) dut_a (
        .clk(clk), .reset(reset_a),
        .req_valid(valid_a), .req_write(write_a), .req_addr(addr_a), .req_wdata(wdata_a),
        .req_ready(ready_a), .resp_valid(rvalid_a), .resp_rdata(rdata_a),
        .resp_err(err_a), .stall_mem(stall_a)
    );

    dmem_responder #(.ADDR_W(10), .LATENCY(0)) dut_b (
        .clk(clk), .reset(reset_b),
        .req_valid(valid_b), .req_write(write_b), .req_addr(addr_b), .req_wdata(wdata_b),
        .req_ready(ready_b), .resp_valid(rvalid_b), .resp_rdata(rdata_b),
        .resp_err(err_b), .stall_mem(stall_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end else begin
            passes++;
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            valid_b = v; write_b = w; addr_b = a; wdata_b = d;
        end else begin
            valid_a = v; write_a = w; addr_a = a; wdata_a = d;
        end
    endtask

    // Called just after a rising edge; holds the request until the response
    // cycle ends, then drops it. exp_cycles counts from the first request cycle.
    task automatic apply_stimulus(input string tag, input bit sel, input logic w, input logic [31:0] a,
                                  input logic [31:0] d, input int exp_cycles,
                                  output logic [31:0] rdata, output logic err);
        int  n;
        bit  got;
        n     = 0;
        got   = 0;
        rdata = 32'hxxxxxxxx;
        err   = 1'bx;
        drive(sel, 1'b1, w, a, d);
        @(negedge clk);
        while (n < 20 && !got) begin
            if (sel ? rvalid_b : rvalid_a) begin
                got   = 1;
                rdata = sel ? rdata_b : rdata_a;
                err   = sel ? err_b : err_a;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        check_output({tag, "_latency"}, 32'(n), 32'(exp_cycles));
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_outputs", {27'd0, ready_a, rvalid_a, err_a, stall_a, 1'b0}, {27'd0, 5'b10000});
        check_output("reset_rdata", rdata_a, 32'd0);
        @(posedge clk);
        #1;
        reset_a = 1'b0;
        reset_b = 1'b0;

        // Store then load, LATENCY=2
        apply_stimulus("st_beef", 0, 1'b1, 32'h40, 32'hDEADBEEF, 3, rd, er);
        check_output("st_beef_rdata", rd, 32'd0);
        check_output("st_beef_err", {31'd0, er}, 32'd0);
        apply_stimulus("ld_beef", 0, 1'b0, 32'h40, 32'd0, 3, rd, er);
        check_output("ld_beef_rdata", rd, 32'hDEADBEEF);
        check_output("ld_beef_err", {31'd0, er}, 32'd0);

        // Continuous stream of three loads over twelve cycles
        stall_count = 0;
        resp_count  = 0;
        drive(0, 1'b1, 1'b0, 32'h40, 32'd0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            case (k % 4)
                0:       exp_flags = 3'b110;
                3:       exp_flags = 3'b001;
                default: exp_flags = 3'b010;
            endcase
            check_output($sformatf("stream_c%0d", k), {29'd0, ready_a, stall_a, rvalid_a}, {29'd0, exp_flags});
            if (stall_a) stall_count++;
            if (rvalid_a) resp_count++;
            @(posedge clk);
            #1;
        end
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        check_output("stream_stalls", 32'(stall_count), 32'd9);
        check_output("stream_resps", 32'(resp_count), 32'd3);

        // Misaligned load
        apply_stimulus("st_1111", 0, 1'b1, 32'h40, 32'h11111111, 3, rd, er);
        apply_stimulus("ld_mis", 0, 1'b0, 32'h42, 32'd0, 3, rd, er);
        check_output("ld_mis_err", {31'd0, er}, 32'd1);
        check_output("ld_mis_rdata", rd, 32'd0);
        apply_stimulus("ld_1111", 0, 1'b0, 32'h40, 32'd0, 3, rd, er);
        check_output("ld_1111_rdata", rd, 32'h11111111);
        check_output("ld_1111_err", {31'd0, er}, 32'd0);

        // Reset during the wait of a store
        apply_stimulus("st_cafe", 0, 1'b1, 32'h80, 32'hCAFEF00D, 3, rd, er);
        drive(0, 1'b1, 1'b1, 32'h80, 32'h12345678);
        @(posedge clk);
        #1;
        check_output("wait_flags", {30'd0, ready_a, stall_a}, {30'd0, 2'b01});
        reset_a = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        check_output("wait_reset_outputs", {28'd0, ready_a, rvalid_a, err_a, stall_a}, {28'd0, 4'b1000});
        check_output("wait_reset_rdata", rdata_a, 32'd0);
        @(posedge clk);
        #1;
        reset_a = 1'b0;
        resp_count = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rvalid_a) resp_count++;
        end
        check_output("wait_reset_noresp", 32'(resp_count), 32'd0);
        @(posedge clk);
        #1;
        apply_stimulus("ld_cafe", 0, 1'b0, 32'h80, 32'd0, 3, rd, er);
        check_output("ld_cafe_rdata", rd, 32'hCAFEF00D);

        // Zero-latency instance
        apply_stimulus("b_st5", 1, 1'b1, 32'h10, 32'h00000005, 1, rd, er);
        check_output("b_st5_rdata", rd, 32'd0);
        apply_stimulus("b_ld5", 1, 1'b0, 32'h10, 32'd0, 1, rd, er);
        check_output("b_ld5_rdata", rd, 32'h00000005);
        check_output("b_ld5_err", {31'd0, er}, 32'd0);

        // Aliasing modulo the memory size
        apply_stimulus("st_alias", 0, 1'b1, 32'h1004, 32'hA5A5A5A5, 3, rd, er);
        apply_stimulus("ld_alias", 0, 1'b0, 32'h0004, 32'd0, 3, rd, er);
        check_output("ld_alias_rdata", rd, 32'hA5A5A5A5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
